// File: rtl/fetch_group_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_group_sender_pkg
// Description : Shared frontend types and constants for the fetch-group
//               producer (line width, PC width, slot count, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_group_sender_pkg;

    localparam int c_PC_WIDTH            = 64;
    localparam int c_ICACHE_FETCHWIDTH128 = 128;
    localparam int c_SLOT_COUNT          = 4;
    localparam int c_SLOT_WIDTH          = 32;

    typedef logic [c_PC_WIDTH-1:0]             pc_t;
    typedef logic [c_ICACHE_FETCHWIDTH128-1:0] line_t;
    typedef logic [c_SLOT_COUNT-1:0]           slot_mask_t;

    // Fetch sequencing states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } fetch_state_e;

    // Clear the byte-within-line bits of a fetch address
    function automatic pc_t line_align(input pc_t addr);
        return addr & ~pc_t'(15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_group_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_group_sender_if
// Description : Bundle of the fetch request, I-cache, branch predictor and
//               instruction-buffer signals around the fetch-group producer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_group_sender_if;
    import fetch_group_sender_pkg::*;

    logic       fetch_inst;
    logic       redirect_valid;
    pc_t        redirect_target;

    logic       ic_req_valid;
    logic       ic_req_ready;
    pc_t        ic_req_addr;
    logic       ic_resp_valid;
    line_t      ic_resp_data;

    slot_mask_t bpu_taken;
    line_t      bpu_target;

    line_t      admin2ib_instr;
    slot_mask_t admin2ib_instr_valid;
    slot_mask_t admin2ib_predicttaken;
    line_t      admin2ib_predicttarget;
    pc_t        pc;
    logic       pc_operation_done;

    // Fetch-group producer side
    modport master (
        input  fetch_inst, redirect_valid, redirect_target,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  bpu_taken, bpu_target,
        output ic_req_valid, ic_req_addr,
        output admin2ib_instr, admin2ib_instr_valid,
        output admin2ib_predicttaken, admin2ib_predicttarget,
        output pc, pc_operation_done
    );

    // Buffer / cache / backend side
    modport slave (
        output fetch_inst, redirect_valid, redirect_target,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output bpu_taken, bpu_target,
        input  ic_req_valid, ic_req_addr,
        input  admin2ib_instr, admin2ib_instr_valid,
        input  admin2ib_predicttaken, admin2ib_predicttarget,
        input  pc, pc_operation_done
    );

endinterface
`default_nettype wire

// File: rtl/fetch_group_sender_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mask_gen
// Description : Slot valid mask for a fetch group. Slots before the fetch
//               offset are unfetched; slots after the first predicted-taken
//               valid slot are dropped. Also reports the taken slot index.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_mask_gen
    import fetch_group_sender_pkg::*;
(
    input  wire logic [1:0]  i_slot_offset,
    input  wire slot_mask_t  i_bpu_taken,
    output slot_mask_t       o_valid_mask,
    output logic             o_taken_hit,
    output logic [1:0]       o_taken_idx
);

    logic w_blocked;

    // Walk the slots in order; the first taken slot at or past the offset
    // closes the group
    always_comb begin
        w_blocked    = 1'b0;
        o_valid_mask = '0;
        o_taken_hit  = 1'b0;
        o_taken_idx  = 2'd0;
        for (int i = 0; i < c_SLOT_COUNT; i++) begin
            if ((i >= int'(i_slot_offset)) && !w_blocked) begin
                o_valid_mask[i] = 1'b1;
                if (i_bpu_taken[i]) begin
                    w_blocked   = 1'b1;
                    o_taken_hit = 1'b1;
                    o_taken_idx = i[1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_group_sender.sv
`default_nettype none
// ============================================================================
// Module      : fetch_group_sender
// Description : Producer side of the fetch-group interface. Turns a buffer
//               fetch request into an I-cache line request, captures the
//               line plus branch predictions and presents one masked 4-slot
//               group for a single cycle. Owns the fetch PC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_group_sender
    import fetch_group_sender_pkg::*;
#(
    parameter pc_t RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int  LINE_BYTES = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    fetch_group_sender_if.master  bus
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;

    pc_t          r_pc;
    pc_t          r_next_pc;
    logic         r_drop_resp;

    line_t        r_instr;
    slot_mask_t   r_instr_valid;
    slot_mask_t   r_predicttaken;
    line_t        r_predicttarget;
    pc_t          r_group_pc;
    logic         r_done;

    logic         w_capture;
    logic         w_outstanding;
    slot_mask_t   w_valid_mask;
    logic         w_taken_hit;
    logic [1:0]   w_taken_idx;
    line_t        w_line_mask;
    pc_t          w_group_next_pc;

    fetch_mask_gen u_mask_gen (
        .i_slot_offset (r_pc[3:2]),
        .i_bpu_taken   (bus.bpu_taken),
        .o_valid_mask  (w_valid_mask),
        .o_taken_hit   (w_taken_hit),
        .o_taken_idx   (w_taken_idx)
    );

    // Widen the slot mask to a per-bit line mask
    for (genvar gi = 0; gi < c_SLOT_COUNT; gi++) begin : g_slot_mask
        assign w_line_mask[gi*c_SLOT_WIDTH +: c_SLOT_WIDTH] = {c_SLOT_WIDTH{w_valid_mask[gi]}};
    end

    // A line is taken from the cache only when it is the live response in WAIT
    assign w_capture = (r_state == WAIT) && bus.ic_resp_valid && !r_drop_resp
                       && !bus.redirect_valid;

    // A redirect abandons an in-flight request whose response is still coming
    assign w_outstanding = (r_state == WAIT) || ((r_state == REQ) && bus.ic_req_ready);

    // Taken branch wins over the sequential line advance
    assign w_group_next_pc = w_taken_hit
        ? {32'b0, bus.bpu_target[{w_taken_idx, 5'b0} +: c_SLOT_WIDTH]}
        : line_align(r_pc) + pc_t'(LINE_BYTES);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect overrides every state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.fetch_inst)   w_next_state = REQ;
            REQ:     if (bus.ic_req_ready) w_next_state = WAIT;
            WAIT:    if (bus.ic_resp_valid && !r_drop_resp) w_next_state = SEND;
            SEND:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (bus.redirect_valid) begin
            w_next_state = IDLE;
        end
    end

    // Fetch PC: redirect first, otherwise commit the group's successor in SEND
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_next_pc <= '0;
        end else begin
            if (w_capture) begin
                r_next_pc <= w_group_next_pc;
            end
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_target;
            end else if (r_state == SEND) begin
                r_pc <= r_next_pc;
            end
        end
    end

    // Stale-response filter: one response is swallowed after a flushed request
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_resp <= 1'b0;
        end else if (bus.redirect_valid && w_outstanding) begin
            r_drop_resp <= 1'b1;
        end else if (bus.ic_resp_valid) begin
            r_drop_resp <= 1'b0;
        end
    end

    // Group output registers: valid/done pulse for one cycle, data holds
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr         <= '0;
            r_instr_valid   <= '0;
            r_predicttaken  <= '0;
            r_predicttarget <= '0;
            r_group_pc      <= '0;
            r_done          <= 1'b0;
        end else begin
            r_instr_valid <= '0;
            r_done        <= 1'b0;
            if (w_capture) begin
                r_instr         <= bus.ic_resp_data & w_line_mask;
                r_instr_valid   <= w_valid_mask;
                r_predicttaken  <= bus.bpu_taken & w_valid_mask;
                r_predicttarget <= bus.bpu_target;
                r_group_pc      <= r_pc;
                r_done          <= 1'b1;
            end
        end
    end

    assign bus.ic_req_valid           = (r_state == REQ);
    assign bus.ic_req_addr            = (r_state == REQ) ? line_align(r_pc) : '0;
    assign bus.admin2ib_instr         = r_instr;
    assign bus.admin2ib_instr_valid   = r_instr_valid;
    assign bus.admin2ib_predicttaken  = r_predicttaken;
    assign bus.admin2ib_predicttarget = r_predicttarget;
    assign bus.pc                     = r_group_pc;
    assign bus.pc_operation_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_group_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_group_sender
// Description : Self-checking bench for fetch_group_sender: directed cases
//               followed by randomized fetch/redirect traffic checked against
//               a transaction-level PC and slot-mask model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_group_sender;
    import fetch_group_sender_pkg::*;

    localparam logic [63:0] c_RESET_PC = 64'h0000_0000_8000_0000;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [63:0] m_pc;
    bit          m_drop;

    fetch_group_sender_if bus ();

    fetch_group_sender #(
        .RESET_PC   (c_RESET_PC),
        .LINE_BYTES (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Slots off..last are valid, where last is the first taken slot at or
    // after off (or slot 3 when none is taken)
    function automatic logic [3:0] exp_mask(input logic [63:0] p, input logic [3:0] tk);
        int off  = int'(p[3:2]);
        int last = 3;
        for (int k = 3; k >= off; k--) if (tk[k]) last = k;
        return 4'(((1 << (last + 1)) - 1) & ~((1 << off) - 1));
    endfunction

    function automatic logic [63:0] exp_next(input logic [63:0] p, input logic [3:0] tk,
                                             input logic [127:0] tg);
        int off = int'(p[3:2]);
        for (int k = off; k < 4; k++) if (tk[k]) return {32'b0, tg[k*32 +: 32]};
        return (p & ~64'hF) + 64'd16;
    endfunction

    function automatic logic [127:0] expand(input logic [3:0] m);
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*32 +: 32] = 32'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_valid"}, bus.ic_req_valid, 0);
        check_eq({tag, "_req_addr"},  bus.ic_req_addr, 0);
        check_eq({tag, "_valid"},     bus.admin2ib_instr_valid, 0);
        check_eq({tag, "_done"},      bus.pc_operation_done, 0);
        check_eq({tag, "_instr"},     bus.admin2ib_instr, 0);
        check_eq({tag, "_ptaken"},    bus.admin2ib_predicttaken, 0);
        check_eq({tag, "_ptarget"},   bus.admin2ib_predicttarget, 0);
        check_eq({tag, "_pc"},        bus.pc, 0);
    endtask

    // Raise fetch_inst from IDLE and wait (bounded) for the request
    task automatic start_req(output bit ok);
        int waited = 0;
        bus.fetch_inst = 1'b1;
        while (!bus.ic_req_valid && waited < 8) begin
            tick();
            waited++;
        end
        check_eq("req_valid", bus.ic_req_valid, 1);
        bus.fetch_inst = 1'b0;
        ok = bus.ic_req_valid;
    endtask

    // One complete fetch group, including a stale response if one is owed
    task automatic do_group(input logic [3:0] tk, input logic [127:0] tg,
                            input logic [127:0] data, input int stall, input int rdly);
        int          start;
        bit          ok;
        bit          had_drop;
        logic [63:0] a0;
        logic [3:0]  m;
        start    = cyc;
        had_drop = m_drop;
        start_req(ok);
        if (!ok) return;
        check_eq("req_addr", bus.ic_req_addr, m_pc & ~64'hF);
        a0 = bus.ic_req_addr;
        for (int s = 0; s < stall; s++) begin
            tick();
            check_eq("hold_valid", bus.ic_req_valid, 1);
            check_eq("hold_addr", bus.ic_req_addr, a0);
        end
        bus.ic_req_ready = 1'b1;
        tick();
        bus.ic_req_ready = 1'b0;
        check_eq("req_accepted", bus.ic_req_valid, 0);
        if (m_drop) begin
            bus.ic_resp_valid = 1'b1;
            bus.ic_resp_data  = rand128();
            bus.bpu_taken     = 4'($urandom);
            tick();
            bus.ic_resp_valid = 1'b0;
            m_drop = 1'b0;
            check_eq("stale_done", bus.pc_operation_done, 0);
            check_eq("stale_valid", bus.admin2ib_instr_valid, 0);
        end
        repeat (rdly) tick();
        bus.ic_resp_valid = 1'b1;
        bus.ic_resp_data  = data;
        bus.bpu_taken     = tk;
        bus.bpu_target    = tg;
        tick();
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_data  = rand128();
        bus.bpu_taken     = 4'($urandom);
        bus.bpu_target    = rand128();
        m = exp_mask(m_pc, tk);
        if (stall == 0 && rdly == 0 && !had_drop) check_eq("latency", 32'(cyc - start), 3);
        check_eq("done", bus.pc_operation_done, 1);
        check_eq("valid", bus.admin2ib_instr_valid, m);
        check_eq("instr", bus.admin2ib_instr, data & expand(m));
        check_eq("ptaken", bus.admin2ib_predicttaken, tk & m);
        check_eq("ptarget", bus.admin2ib_predicttarget, tg);
        check_eq("group_pc", bus.pc, m_pc);
        m_pc = exp_next(m_pc, tk, tg);
        tick();
        check_eq("done_pulse", bus.pc_operation_done, 0);
        check_eq("valid_pulse", bus.admin2ib_instr_valid, 0);
    endtask

    task automatic redirect_idle(input logic [63:0] t);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
        tick();
        bus.redirect_valid  = 1'b0;
        check_eq("redir_idle_done", bus.pc_operation_done, 0);
        m_pc = t;
    endtask

    // Flush an in-flight request: in WAIT (in_req=0) or on the REQ accept
    // cycle (in_req=1); optionally deliver the stale response right away
    task automatic redirect_inflight(input logic [63:0] t, input bit in_req, input bit stale_now);
        bit ok;
        start_req(ok);
        if (!ok) return;
        bus.ic_req_ready = 1'b1;
        if (!in_req) begin
            tick();
            bus.ic_req_ready = 1'b0;
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
        tick();
        bus.redirect_valid = 1'b0;
        bus.ic_req_ready   = 1'b0;
        m_pc   = t;
        m_drop = 1'b1;
        check_eq("redir_done", bus.pc_operation_done, 0);
        check_eq("redir_req", bus.ic_req_valid, 0);
        if (stale_now) begin
            bus.ic_resp_valid = 1'b1;
            bus.ic_resp_data  = rand128();
            tick();
            bus.ic_resp_valid = 1'b0;
            m_drop = 1'b0;
            check_eq("stale_now_done", bus.pc_operation_done, 0);
            tick();
            check_eq("stale_now_valid", bus.admin2ib_instr_valid, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [127:0] tg;
        bit ok;
        bus.fetch_inst      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.ic_req_ready    = 1'b0;
        bus.ic_resp_valid   = 1'b0;
        bus.ic_resp_data    = '0;
        bus.bpu_taken       = '0;
        bus.bpu_target      = '0;
        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset  = 1'b0;
        m_pc   = c_RESET_PC;
        m_drop = 1'b0;

        // Sequential groups from the reset PC
        do_group(4'b0000, rand128(), rand128(), 0, 0);
        redirect_idle(64'h8000_0008);
        do_group(4'b0000, rand128(), rand128(), 0, 0);
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Taken branch in slot 1 closes the group and redirects fetch
        redirect_idle(64'h8000_0000);
        tg = rand128();
        tg[63:32] = 32'h8000_0100;
        do_group(4'b0010, tg, rand128(), 0, 0);
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Taken in an unfetched slot is ignored
        redirect_idle(64'h8000_0004);
        do_group(4'b0001, rand128(), rand128(), 0, 0);
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Flush in WAIT with the stale response on the following cycle
        redirect_inflight(64'h8000_2004, 1'b0, 1'b1);
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Flush on the accept cycle; the next request's first response is stale
        redirect_inflight(64'h8000_3000, 1'b1, 1'b0);
        do_group(4'b0000, rand128(), rand128(), 0, 1);

        // Request held for five cycles without ready
        do_group(4'b0100, rand128(), rand128(), 5, 0);

        // 64-bit wrap of the sequential advance
        redirect_idle(64'hFFFF_FFFF_FFFF_FFF8);
        do_group(4'b0000, rand128(), rand128(), 0, 0);
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Reset while waiting on the cache
        start_req(ok);
        bus.ic_req_ready = 1'b1;
        tick();
        bus.ic_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_wait");
        m_pc   = c_RESET_PC;
        m_drop = 1'b0;
        do_group(4'b0000, rand128(), rand128(), 0, 0);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            int sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                redirect_idle({$urandom, $urandom} & ~64'h3);
            end else if (sel == 1) begin
                redirect_inflight({$urandom, $urandom} & ~64'h3,
                                  1'($urandom), 1'($urandom));
            end else begin
                logic [3:0]   tk;
                logic [127:0] rt;
                tk = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
                rt = rand128();
                for (int i = 0; i < 4; i++) rt[i*32 +: 2] = 2'b00;
                do_group(tk, rt, rand128(), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_group_sender.md
Name: fetch_group_sender

Overview:
- Producer side of the fetch-group interface into the instruction buffer. Converts the buffer's fetch request pulse into an I-cache line request and captures the 128-bit response with per-slot branch predictions.
- Presents one 4-slot fetch group with a valid mask. Unfetched leading slots are zero. Slots after a predicted-taken branch are dropped.
- Owns the fetch PC: sequential advance, predicted-taken redirect, backend redirect.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.
- LINE_BYTES, 16, fetch group size in bytes; fixed at 4 x 32-bit slots.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_inst  in  1  buffer requests a new group (level, sampled in IDLE)
- redirect_valid  in  1  backend flush
- redirect_target  in  64  new fetch PC on flush
- ic_req_valid  out  1  I-cache request valid
- ic_req_ready  in  1  I-cache accepts request
- ic_req_addr  out  64  line-aligned request address (pc & ~64'hF)
- ic_resp_valid  in  1  I-cache response valid (one cycle)
- ic_resp_data  in  128  line data; slot i = bits [32i+31:32i]
- bpu_taken  in  4  per-slot predicted-taken, valid with ic_resp_valid
- bpu_target  in  128  per-slot predicted target, 32 bits each
- admin2ib_instr  out  128  group data, slot-ordered
- admin2ib_instr_valid  out  4  slot valid mask
- admin2ib_predicttaken  out  4  per-slot taken, masked by valid
- admin2ib_predicttarget  out  128  per-slot targets
- pc  out  64  address of first valid slot of the presented group
- pc_operation_done  out  1  one-cycle pulse with each presented group

Behaviour:
- Reset: fetch PC = RESET_PC, state IDLE, drop_resp = 0. All outputs 0, including admin2ib_instr_valid = 4'b0000.
- States:
  - IDLE: if fetch_inst, go to REQ.
  - REQ: ic_req_valid = 1. On ic_req_ready, go to WAIT.
  - WAIT: on ic_resp_valid (and drop_resp = 0), register the group and go to SEND.
  - SEND: outputs valid for exactly one cycle, pc_operation_done = 1, then go to IDLE.
- All group outputs are registered.
  - admin2ib_instr_valid is nonzero only in the SEND cycle; it reads 0 in every other cycle.
  - Data outputs hold their last value outside SEND.
- Valid mask: off = pc[3:2]. Slot i is valid iff i >= off and no slot j with off <= j < i has bpu_taken[j] = 1. The valid slots are therefore contiguous, with leading zeros.
- Next PC:
  - If any valid slot k has bpu_taken[k] = 1 (lowest k), next PC = zero-extended bpu_target[k].
  - Otherwise next PC = (pc & ~64'hF) + 16.
  - Next PC is committed in the SEND cycle. 64-bit wrap is allowed.
- Output pc = current fetch PC, already pointing at slot `off`.
- Minimum latency: fetch_inst seen in IDLE at cycle 0 -> REQ at cycle 1. With ready and a 1-cycle response, SEND occurs at cycle 3.
- Redirect (highest priority, any state): fetch PC <= redirect_target, state <= IDLE, and no SEND that cycle.
  - If a request is outstanding (state WAIT, or REQ with ic_req_ready in the same cycle), set drop_resp.
  - The next ic_resp_valid is discarded and clears drop_resp.
  - A new request may be issued while drop_resp = 1. The first response is dropped; the second is used.
- fetch_inst in non-IDLE states is ignored; no queueing.
- Response with a mask of all zeros cannot occur: the slot at `off` is always valid.

Decomposition:
- Shared frontend package holds:
  - ICACHE_FETCHWIDTH128 range
  - PC range
  - the slot count constant (4)
  - the FSM state enum (IDLE/REQ/WAIT/SEND)
- One sub-module, fetch_mask_gen: combinational. Inputs pc[3:2] and bpu_taken. Outputs the valid mask, taken_hit, and taken_idx.

Test Plan:
- Reset then fetch_inst = 1, ic_req_ready = 1, response 1 cycle later, no taken:
  - ic_req_addr = 0x80000000
  - SEND at cycle 3 with valid = 4'b1111, pc = 0x80000000
  - next request at 0x80000010
- PC = 0x80000008, no taken -> valid = 4'b1100, pc = 0x80000008, next PC = 0x80000010.
- PC = 0x80000000, bpu_taken = 4'b0010, target[1] = 0x80000100:
  - valid = 4'b0011, predicttaken = 4'b0010
  - next ic_req_addr = 0x80000100, pc = 0x80000100
- PC = 0x80000004 with bpu_taken = 4'b0001 (taken in a masked slot) -> ignored; valid = 4'b1110, next PC = 0x80000010.
- redirect_valid (target 0x80002004) while in WAIT:
  - the stale response arriving the next cycle produces no SEND
  - the following fetch requests 0x80002000; group valid = 4'b1110, pc = 0x80002004
- ic_req_ready held 0 for 5 cycles -> ic_req_valid and ic_req_addr stay stable. Reset asserted mid-WAIT -> all outputs 0 and pc returns to RESET_PC.
